// File: rtl/zigzag_scan_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : zigzag_scan_buf_if
//  Description : Column-in / zigzag-beat-out handshake bundle for zigzag_scan_buf.
//  Revision    : 1.0 - initial release
// ============================================================================
interface zigzag_scan_buf_if #(
    parameter int DW    = 21,
    parameter int OUT_W = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*DW-1:0]       in_col;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_W*DW-1:0]   out_data;
    logic [5:0]            out_idx;
    logic                  out_last;
    logic [OUT_W-1:0]      out_last_nz;

    // The reorder buffer itself
    modport slave (
        input  in_valid, in_col, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, out_last_nz
    );

    // Upstream quantiser / downstream coder side
    modport master (
        output in_valid, in_col, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, out_last_nz
    );
endinterface
`default_nettype wire

// File: rtl/zigzag_scan_buf.sv
`default_nettype none
// ============================================================================
//  Module      : zigzag_scan_buf
//  Description : Ping-pong 8x8 zigzag reorder buffer, columns in, OUT_W coeffs
//                per beat out. Optional macro ZIGZAG_LAST_NZ_EN adds the
//                last-nonzero lane marker.
//  Revision    : 1.0 - initial release
// ============================================================================
module zigzag_scan_buf #(
    parameter int DW    = 21,
    parameter int OUT_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    zigzag_scan_buf_if.slave bus
);
    if (!(OUT_W == 1 || OUT_W == 2 || OUT_W == 4 || OUT_W == 8)) begin : g_bad_out_w
        $error("zigzag_scan_buf: OUT_W must be 1, 2, 4 or 8");
    end

    localparam logic [5:0] C_LAST_IDX = 6'(64 - OUT_W);

    // Zigzag index indexed by raster position {row, col}
    localparam logic [5:0] C_ZZ [64] = '{
        6'd0,  6'd1,  6'd5,  6'd6,  6'd14, 6'd15, 6'd27, 6'd28,
        6'd2,  6'd4,  6'd7,  6'd13, 6'd16, 6'd26, 6'd29, 6'd42,
        6'd3,  6'd8,  6'd12, 6'd17, 6'd25, 6'd30, 6'd41, 6'd43,
        6'd9,  6'd11, 6'd18, 6'd24, 6'd31, 6'd40, 6'd44, 6'd53,
        6'd10, 6'd19, 6'd23, 6'd32, 6'd39, 6'd45, 6'd52, 6'd54,
        6'd20, 6'd22, 6'd33, 6'd38, 6'd46, 6'd51, 6'd55, 6'd60,
        6'd21, 6'd34, 6'd37, 6'd47, 6'd50, 6'd56, 6'd59, 6'd61,
        6'd35, 6'd36, 6'd48, 6'd49, 6'd57, 6'd58, 6'd62, 6'd63
    };

    logic [DW-1:0]       r_mem [2][64];
    logic [1:0]          r_full;
    logic                r_wr_bank;
    logic                r_rd_bank;
    logic [2:0]          r_wr_col;
    logic [5:0]          r_rd_idx;

    logic                w_in_ready;
    logic                w_out_valid;
    logic                w_wr_fire;
    logic                w_rd_fire;
    logic                w_rd_last;
    logic [1:0]          w_set;
    logic [1:0]          w_clr;
    logic [OUT_W*DW-1:0] w_rd_data;

    assign w_in_ready  = ~r_full[r_wr_bank];
    assign w_out_valid = r_full[r_rd_bank];
    assign w_wr_fire   = bus.in_valid & w_in_ready;
    assign w_rd_fire   = w_out_valid & bus.out_ready;
    assign w_rd_last   = w_out_valid & (r_rd_idx == C_LAST_IDX);

    // Set and clear always address different banks, so both may land together
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_wr_fire && r_wr_col == 3'd7) w_set[r_wr_bank] = 1'b1;
        if (w_rd_fire && w_rd_last)        w_clr[r_rd_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_col  <= 3'd0;
            r_rd_idx  <= 6'd0;
        end else begin
            r_full <= (r_full & ~w_clr) | w_set;
            if (w_wr_fire) begin
                r_wr_col <= r_wr_col + 3'd1;
                if (r_wr_col == 3'd7) r_wr_bank <= ~r_wr_bank;
            end
            if (w_rd_fire) begin
                if (w_rd_last) begin
                    r_rd_idx  <= 6'd0;
                    r_rd_bank <= ~r_rd_bank;
                end else begin
                    r_rd_idx  <= r_rd_idx + 6'(OUT_W);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int r = 0; r < 8; r++) begin
                r_mem[r_wr_bank][C_ZZ[{3'(r), r_wr_col}]] <= bus.in_col[r*DW +: DW];
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int k = 0; k < OUT_W; k++) begin
            w_rd_data[k*DW +: DW] = r_mem[r_rd_bank][r_rd_idx + 6'(k)];
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_valid ? w_rd_data : '0;
    assign bus.out_idx   = r_rd_idx;
    assign bus.out_last  = w_rd_last;

`ifdef ZIGZAG_LAST_NZ_EN
    logic [5:0]       r_lnz [2];
    logic [1:0]       r_any_nz;
    logic [5:0]       w_col_max;
    logic             w_col_nz;
    logic [OUT_W-1:0] w_last_nz;

    always_comb begin
        w_col_max = '0;
        w_col_nz  = 1'b0;
        for (int r = 0; r < 8; r++) begin
            if (bus.in_col[r*DW +: DW] != '0) begin
                w_col_nz = 1'b1;
                if (C_ZZ[{3'(r), r_wr_col}] > w_col_max) w_col_max = C_ZZ[{3'(r), r_wr_col}];
            end
        end
    end

    // Column 0 restarts the running maximum for the bank being filled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lnz[0] <= 6'd0;
            r_lnz[1] <= 6'd0;
            r_any_nz <= '0;
        end else if (w_wr_fire) begin
            if (r_wr_col == 3'd0) begin
                r_lnz[r_wr_bank]    <= w_col_max;
                r_any_nz[r_wr_bank] <= w_col_nz;
            end else if (w_col_nz && (!r_any_nz[r_wr_bank] || w_col_max > r_lnz[r_wr_bank])) begin
                r_lnz[r_wr_bank]    <= w_col_max;
                r_any_nz[r_wr_bank] <= 1'b1;
            end
        end
    end

    always_comb begin
        w_last_nz = '0;
        for (int k = 0; k < OUT_W; k++) begin
            w_last_nz[k] = w_out_valid & r_any_nz[r_rd_bank] &
                           ((r_rd_idx + 6'(k)) == r_lnz[r_rd_bank]);
        end
    end

    assign bus.out_last_nz = w_last_nz;
`else
    assign bus.out_last_nz = '0;
`endif

endmodule
`default_nettype wire
